// File: rtl/iq_chan_arbiter.sv
// iq_chan_arbiter: captures per-channel decimated I/Q pairs into holding slots
// and drains them round-robin into one valid/ready stream tagged by channel.
module iq_chan_arbiter #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     CLK,
    input  logic                     RSTb,
    input  logic [NUM_CH*DATA_W-1:0] in_I,
    input  logic [NUM_CH*DATA_W-1:0] in_Q,
    input  logic [NUM_CH-1:0]        in_tick,
    input  logic [NUM_CH-1:0]        chan_en,
    output logic [DATA_W-1:0]        out_I,
    output logic [DATA_W-1:0]        out_Q,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH-1:0]        overrun,
    input  logic                     overrun_clr
);

    localparam int unsigned NCH = NUM_CH;

    logic [DATA_W-1:0] slot_i [NUM_CH];
    logic [DATA_W-1:0] slot_q [NUM_CH];
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] pending_d;
    logic [NUM_CH-1:0] capture;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] grant_oh;
    logic [NUM_CH-1:0] ovr_set;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   grant_ch;
    logic              grant_any;
    logic              out_free;
    logic              grant;

    // Round-robin search starting one past the last granted channel.
    // A channel being disabled this cycle is not eligible, so its sample is dropped.
    always_comb begin
        grant_any = 1'b0;
        grant_ch  = '0;
        eligible  = pending & chan_en;
        for (int unsigned i = 1; i <= NCH; i++) begin
            logic [CH_W-1:0] idx;
            idx = CH_W'((32'(ptr) + i) % NCH);
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                grant_ch  = idx;
            end
        end
    end

    // Per-channel capture, pending and overrun update terms.
    // A tick on the granting edge refills the slot, so pending stays set without overrun.
    always_comb begin
        out_free  = !out_valid || out_ready;
        grant     = out_free && grant_any;
        capture   = in_tick & chan_en;
        grant_oh  = '0;
        pending_d = '0;
        ovr_set   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            grant_oh[k]  = grant && (grant_ch == CH_W'(k));
            pending_d[k] = chan_en[k] && (capture[k] || (pending[k] && !grant_oh[k]));
            ovr_set[k]   = capture[k] && pending[k] && !grant_oh[k];
        end
    end

    // Slot storage, pending/overrun flags, output register and round-robin pointer.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                slot_i[k] <= '0;
                slot_q[k] <= '0;
            end
            pending   <= '0;
            overrun   <= '0;
            ptr       <= CH_W'(NCH - 1);
            out_I     <= '0;
            out_Q     <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (capture[k]) begin
                    slot_i[k] <= in_I[k*DATA_W +: DATA_W];
                    slot_q[k] <= in_Q[k*DATA_W +: DATA_W];
                end
            end
            pending <= pending_d;
            overrun <= (overrun & ~{NUM_CH{overrun_clr}}) | ovr_set;
            if (out_free) begin
                if (grant_any) begin
                    out_I     <= slot_i[grant_ch];
                    out_Q     <= slot_q[grant_ch];
                    out_ch    <= grant_ch;
                    out_valid <= 1'b1;
                    ptr       <= grant_ch;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/iq_chan_arbiter.md
Name: iq_chan_arbiter

Overview:
Parametrised N-channel I/Q sample arbiter. It sits between a bank of per-channel NCO/mixer/CIC decimator paths and one shared AM demodulator. Each channel's decimated I/Q pair, qualified by its output tick, is captured into a per-channel holding slot. Slots are drained round-robin into a single valid/ready stream tagged with the channel number, so one am_demod instance can serve several tuned stations.

Parameters:
NUM_CH, 4, number of input channels (2..16)
DATA_W, 16, width of each I and Q sample (two's complement)
CH_W, $clog2(NUM_CH), width of channel tag (derived, not overridden)

Ports:
CLK  in  1  system clock (100 MHz domain)
RSTb  in  1  reset, asynchronous assert, active-low
in_I  in  NUM_CH*DATA_W  packed I samples; channel k at bits [k*DATA_W +: DATA_W]
in_Q  in  NUM_CH*DATA_W  packed Q samples, same packing
in_tick  in  NUM_CH  1-cycle pulse per channel: new I/Q pair present this cycle
chan_en  in  NUM_CH  per-channel enable
out_I  out  DATA_W  arbitrated I sample
out_Q  out  DATA_W  arbitrated Q sample
out_ch  out  CH_W  channel index of out_I/out_Q
out_valid  out  1  output holds a sample
out_ready  in  1  consumer accepts when out_valid & out_ready
overrun  out  NUM_CH  sticky per-channel sample-lost flags
overrun_clr  in  1  clears all overrun bits

Behaviour:
- Reset (RSTb low, asynchronous): out_I=0, out_Q=0, out_ch=0, out_valid=0, overrun=0, all pending bits=0, round-robin pointer=NUM_CH-1 (so channel 0 is granted first). Reset mid-transfer discards all held samples; there is no partial output.
- Capture: on an edge where in_tick[k]=1 and chan_en[k]=1, slot k loads in_I/in_Q for channel k and pending[k] is set. Ticks on disabled channels are ignored.
- Overrun: if pending[k]=1, slot k is not being granted on the same edge, and a new tick arrives, the slot is overwritten with the newer sample (newest wins) and overrun[k] is set.
- Tick coincident with grant of the same channel: the old sample moves to the output register, the new sample loads the slot, pending[k] stays 1, and no overrun is flagged.
- Disable: chan_en[k]=0 clears pending[k] on the next edge. A sample already in the output register is still delivered.
- Output register free condition: out_valid=0, or (out_valid & out_ready) on this edge.
- Grant: when the output register is free and any pending bit is set, select the first pending channel searching pointer+1, pointer+2, ... modulo NUM_CH, wrapping past NUM_CH-1 to 0. On that edge:
  - the slot data and index load into out_I/out_Q/out_ch;
  - out_valid is set;
  - the selected pending bit clears (subject to the coincident-tick rule above);
  - the pointer updates to the selected channel.
- If the output register is free and nothing is pending, out_valid goes to 0.
- Back-to-back: an accept and a new grant can occur on the same edge, giving full throughput of one sample per cycle.
- Stability: out_I, out_Q and out_ch are held constant while out_valid=1 and out_ready=0.
- Latency: with an idle output and no competing channels, a tick at edge t gives out_valid=1 after edge t+1 (capture at t, grant at t+1).
- Fairness: with all channels continuously pending, each channel is granted exactly once per NUM_CH grants.
- overrun_clr: clears all overrun bits on the edge. If a set and a clear happen on the same edge for a bit, the set wins.
- No arithmetic is performed. Data passes bit-exact.

Test Plan:
- Reset: hold RSTb=0 for 3 cycles, then drive in_tick=4'b1111 with RSTb low -> all outputs 0, out_valid=0. After release, no output without new ticks.
- Single channel, NUM_CH=4, out_ready=1: tick ch2 with I=16'h1234, Q=16'hFEDC -> out_valid=1 for exactly one cycle, 2 edges later, with out_ch=2 and data 1234/FEDC.
- Round-robin: ticks on all 4 channels in the same cycle (I=k+1), out_ready=1 -> out_ch sequence 0,1,2,3 on consecutive cycles, I values 1,2,3,4, overrun=0.
- Backpressure and overrun: out_ready=0, tick ch1 three times with I=10,11,12 -> first sample held stable at the output. After out_ready=1, outputs are I=10 then I=12, and overrun=4'b0010. overrun_clr pulse -> overrun=0.
- Coincident tick and grant: ch0 pending, new ch0 tick on its grant edge -> both samples delivered in order, overrun[0]=0.
- Disable: tick ch3, drop chan_en[3] before grant -> no ch3 output. A tick while chan_en[3]=0 -> no pending bit set.
